// File: rtl/multi_queue.sv
// multi_queue: in-order queue of up to DEPTH words; each word is returned on
// data_out with a one-cycle done pulse after a per-transaction wait. The wait
// either grows by one per completed word (MODE=0) or comes from cfg_delay (MODE=1).
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module multi_queue #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int DELAY_BITS = 4,
    parameter int MODE       = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             data_in,
    input  logic [DELAY_BITS-1:0]        cfg_delay,
    output logic                         ready,
    output logic                         done,
    output logic [WIDTH-1:0]             data_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [WIDTH-1:0]      mem [DEPTH];
    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DELAY_BITS-1:0] cnt_q, cnt_d;
    logic [DELAY_BITS-1:0] cur_delay_q, cur_delay_d;
    logic [DELAY_BITS-1:0] delay_reg_q, delay_reg_d;
    logic                  overflow_q, overflow_d;

    logic                  push;
    logic                  pop;
    logic [DELAY_BITS-1:0] latch_delay;

    // A pop never frees a slot in the same cycle: ready looks only at registered level.
    assign ready    = (level_q < LW'(DEPTH));
    assign push     = start & ready;
    assign done     = (state_q == WAIT) && (cnt_q == cur_delay_q);
    assign pop      = done;
    assign data_out = done ? mem[rd_ptr_q] : '0;
    assign level    = level_q;
    assign overflow = overflow_q;

    // Delay to latch when a wait begins; delay_reg_d already holds the
    // post-pop increment, and equals delay_reg_q when nothing is popped.
    assign latch_delay = (MODE == 1) ? cfg_delay : delay_reg_d;

    // Queue bookkeeping: pointers, occupancy, sticky overflow, legacy delay register.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        delay_reg_d = delay_reg_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (start && !ready) overflow_d = 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (pop && (MODE == 0)) delay_reg_d = delay_reg_q + DELAY_BITS'(1);
    end

    // Wait FSM: IDLE until something is queued, then count up to cur_delay per entry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_delay_d = cur_delay_q;

        case (state_q)
            IDLE: begin
                if ((level_q != '0) || push) begin
                    state_d     = WAIT;
                    cnt_d       = '0;
                    cur_delay_d = latch_delay;
                end
            end
            WAIT: begin
                if (!done) begin
                    cnt_d = cnt_q + DELAY_BITS'(1);
                end else if ((level_q > LW'(1)) || push) begin
                    cnt_d       = '0;
                    cur_delay_d = latch_delay;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            cur_delay_q <= '0;
            delay_reg_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            cur_delay_q <= cur_delay_d;
            delay_reg_q <= delay_reg_d;
            overflow_q  <= overflow_d;
        end
    end

    // Word storage written on accepted pushes.
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; data_out is gated by done, so stale contents never show.
        if (push) mem[wr_ptr_q] <= data_in;
    end

endmodule

// File: tb/tb_multi_queue.sv
// Scoreboard bench for multi_queue: one MODE=0 and one MODE=1 instance.
// Stimulus pushes {word, expected done cycle}; per-instance monitors compare on done.
module tb_multi_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int DB    = 4;
    localparam int LW    = $clog2(DEPTH+1);

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } exp_t;

    logic             clock = 1'b0;
    int               cyc   = 0;
    int               n_cmp = 0;
    int               n_mis = 0;
    bit               mon_on = 1'b0;

    logic             rst0, start0, rdy0, done0, ovf0;
    logic [WIDTH-1:0] din0, out0;
    logic [DB-1:0]    cfg0;
    logic [LW-1:0]    lvl0;

    logic             rst1, start1, rdy1, done1, ovf1;
    logic [WIDTH-1:0] din1, out1;
    logic [DB-1:0]    cfg1;
    logic [LW-1:0]    lvl1;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;

    // Legacy-mode wait of the k-th transaction after reset: k mod 16.
    int lat0[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0};

    multi_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DB), .MODE(0)) u0 (
        .clock(clock), .reset(rst0), .start(start0), .data_in(din0), .cfg_delay(cfg0),
        .ready(rdy0), .done(done0), .data_out(out0), .level(lvl0), .overflow(ovf0)
    );

    multi_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DELAY_BITS(DB), .MODE(1)) u1 (
        .clock(clock), .reset(rst1), .start(start1), .data_in(din1), .cfg_delay(cfg1),
        .ready(rdy1), .done(done1), .data_out(out1), .level(lvl1), .overflow(ovf1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic s, input logic [WIDTH-1:0] d);
        start0 = s;
        din0   = d;
        tick();
    endtask

    task automatic drive1(input logic s, input logic [WIDTH-1:0] d);
        start1 = s;
        din1   = d;
        tick();
    endtask

    task automatic drain1(input int budget);
        int n = 0;
        while (sb1.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("u1_drain_complete", sb1.size(), 0);
        repeat (2) tick();
    endtask

    // Monitor for the MODE=0 instance.
    always @(negedge clock) begin
        if (mon_on) begin
            if (done0 === 1'b1) begin
                check("u0_done_expected", sb0.size() != 0, 1);
                if (sb0.size() != 0) begin
                    e0 = sb0.pop_front();
                    check("u0_data", out0, e0.data);
                    check("u0_done_cycle", cyc, e0.cyc);
                end
            end else begin
                check("u0_idle_outputs", {done0, out0}, 0);
            end
        end
    end

    // Monitor for the MODE=1 instance.
    always @(negedge clock) begin
        if (mon_on) begin
            if (done1 === 1'b1) begin
                check("u1_done_expected", sb1.size() != 0, 1);
                if (sb1.size() != 0) begin
                    e1 = sb1.pop_front();
                    check("u1_data", out1, e1.data);
                    check("u1_done_cycle", cyc, e1.cyc);
                end
            end else begin
                check("u1_idle_outputs", {done1, out1}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        logic [WIDTH-1:0] d;

        rst0 = 1'b1; start0 = 1'b0; din0 = '0; cfg0 = '0;
        rst1 = 1'b1; start1 = 1'b0; din1 = '0; cfg1 = '0;
        repeat (2) tick();
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Reset state of both instances.
        check("u0_rst_level", lvl0, 0);
        check("u0_rst_ready", rdy0, 1);
        check("u0_rst_ovf", ovf0, 0);
        check("u0_rst_done_out", {done0, out0}, 0);
        check("u1_rst_level", lvl1, 0);
        check("u1_rst_ready", rdy1, 1);
        check("u1_rst_ovf", ovf1, 0);
        mon_on = 1'b1;

        // Legacy mode: 17 single transactions, wait grows 0..15 then wraps to 0.
        for (int k = 0; k < 17; k++) begin
            d = (k == 0) ? 32'hDEAD_BEEF : (32'hA000_0000 + WIDTH'(k));
            drive0(1'b1, d);
            sb0.push_back('{data: d, cyc: cyc + lat0[k]});
            start0 = 1'b0;
            repeat (lat0[k] + 2) tick();
        end
        check("u0_all_done", sb0.size(), 0);

        // cfg_delay=3, four back-to-back pushes: done every 4 cycles, level peaks at 4.
        cfg1 = 4'd3;
        drive1(1'b1, 32'h11);
        base = cyc;
        sb1.push_back('{data: 32'h11, cyc: base + 3});
        drive1(1'b1, 32'h22);
        sb1.push_back('{data: 32'h22, cyc: base + 7});
        drive1(1'b1, 32'h33);
        sb1.push_back('{data: 32'h33, cyc: base + 11});
        drive1(1'b1, 32'h44);
        sb1.push_back('{data: 32'h44, cyc: base + 15});
        check("t2_level_peak", lvl1, 4);
        check("t2_ready_full", rdy1, 0);
        start1 = 1'b0;
        drain1(40);

        // cfg_delay=15, six pushes into a 4-deep queue: last two dropped, overflow sticks.
        cfg1 = 4'd15;
        drive1(1'b1, 32'h51);
        base = cyc;
        sb1.push_back('{data: 32'h51, cyc: base + 15});
        drive1(1'b1, 32'h52);
        sb1.push_back('{data: 32'h52, cyc: base + 31});
        drive1(1'b1, 32'h53);
        sb1.push_back('{data: 32'h53, cyc: base + 47});
        drive1(1'b1, 32'h54);
        sb1.push_back('{data: 32'h54, cyc: base + 63});
        check("t3_ready_low", rdy1, 0);
        check("t3_ovf_clear_yet", ovf1, 0);
        drive1(1'b1, 32'h55);
        drive1(1'b1, 32'h56);
        check("t3_ovf_set", ovf1, 1);
        check("t3_level_full", lvl1, 4);
        start1 = 1'b0;
        drain1(100);
        check("t3_ovf_sticky", ovf1, 1);
        check("t3_level_empty", lvl1, 0);

        // cfg_delay=2: push lands on the cycle the last entry pops.
        cfg1 = 4'd2;
        drive1(1'b1, 32'h61);
        base = cyc;
        sb1.push_back('{data: 32'h61, cyc: base + 2});
        drive1(1'b0, 32'h0);
        drive1(1'b0, 32'h0);
        drive1(1'b1, 32'h62);
        sb1.push_back('{data: 32'h62, cyc: base + 5});
        check("t5_level_kept", lvl1, 1);
        check("t5_counter_restart", done1, 0);
        start1 = 1'b0;
        drain1(20);

        // Reset with three entries queued and the head mid-wait.
        cfg1 = 4'd5;
        drive1(1'b1, 32'h71);
        drive1(1'b1, 32'h72);
        drive1(1'b1, 32'h73);
        start1 = 1'b0;
        check("t6_level_before", lvl1, 3);
        check("t6_ovf_before", ovf1, 1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("t6_level", lvl1, 0);
        check("t6_done_out", {done1, out1}, 0);
        check("t6_ovf", ovf1, 0);
        check("t6_ready", rdy1, 1);
        repeat (20) tick();
        check("t6_level_after", lvl1, 0);
        check("t6_no_pending", sb1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
